uart_tx_seq16: RTL
==================

Name: uart_tx_seq16

Overview:
UART transmitter stage directly downstream of the operand/ALU-control transmit sequencer. It accepts a start request with 16 data bits and a send16 flag, then serialises one byte, or two bytes back-to-back, as 8N1 frames on the tx line. It returns busy to the sequencer so the sequencer can pace its states. It sits between the sequencer and the board's UART TX pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate in bit/s
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (derived localparam, 868), cycles per serial bit; must be >= 2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tx_start  input  1  request to send; sampled only in IDLE
tx_data  input  16  payload; [7:0] is byte 0 and [15:8] is byte 1
send16  input  1  1 = send both bytes, 0 = send byte 0 only; sampled with tx_start
busy  output  1  high while a transfer is in progress
tx_done  output  1  one-cycle pulse when the whole transfer completes
tx  output  1  serial line; idles high

Behaviour:
- Reset, async and active-high: state=IDLE, tx=1, busy=0, tx_done=0, baud counter=0, bit index=0, byte index=0, data register=0. Reset asserted mid-frame aborts the frame immediately; there is no partial stop bit.
- Acceptance: in IDLE with tx_start=1, capture tx_data and send16 on that edge. In the next cycle busy=1 and tx=0 (start bit begins). tx_start while busy=1 is ignored and not queued.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The bit index wraps from 7 to 0 and the FSM goes to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index=0 and the latched send16=1, set byte index=1 and go to START with no idle gap. Otherwise go to IDLE.
- Completion: on the STOP-to-IDLE transition, tx_done=1 for exactly one cycle and busy drops to 0 in that same cycle. A new tx_start is accepted in that same cycle.
- Frame timing: 1 byte = 10*CLKS_PER_BIT cycles of busy. 2 bytes = 20*CLKS_PER_BIT cycles, with byte 0 sent first.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary. Width is $clog2(CLKS_PER_BIT).
- tx is a registered output (glitch-free). busy and tx_done are registered.
- Changes on tx_data or send16 during busy have no effect on the frame in progress.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. A frame becomes 11 bits, so busy lasts 11 or 22 bit periods.
- Undefined: 8N1 as above; the PARITY state and its logic do not exist.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef tx_state_t (IDLE, START, DATA, STOP, PARITY under the macro);
  - localparam DATA_BITS=8;
  - the function clks_per_bit(clk_freq, baud).
- One sub-module, uart_baud_tick: a counter that emits a one-cycle tick every CLKS_PER_BIT cycles and is cleared by the FSM on frame start. The FSM advances only on tick.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> tx=1, busy=0, tx_done=0 immediately, with no clock edge required.
- Single byte: CLK_FREQ=16, BAUD_RATE=1 (16 cycles/bit); tx_start=1 for 1 cycle with tx_data=16'h00A5, send16=0 -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop), each held 16 cycles; busy high for exactly 160 cycles; tx_done pulses once on the cycle busy falls.
- Two bytes: tx_data=16'h3C5A, send16=1 -> byte 5A frame, then 3C frame with no idle cycle between the stop and start bits; busy high for exactly 320 cycles; one tx_done.
- Ignored start: pulse tx_start with 16'hFFFF at cycle 50 of a transfer of 16'h0011 -> the serial output is unchanged and no second frame follows.
- Back-to-back: hold tx_start=1 continuously, alternating send16 -> the next transfer starts on the tx_done cycle and tx shows no idle bit between transfers.
- Parity (with UART_TX_PARITY_EN): tx_data=16'h0007, send16=0 -> a parity bit of 1 appears after the data bits; busy high for 176 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx_seq16 transmitter.
//   tx_state_t   : transmitter FSM states (PARITY exists only when
//                  UART_TX_PARITY_EN is defined)
//   DATA_BITS    : payload bits per serial frame
//   clks_per_bit : clock cycles per serial bit for a given clock/baud pair
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_seq16_if.sv
// Handshake between the transmit sequencer (master) and the UART
// transmitter (slave).
//   tx_start : request to send, honoured only while the transmitter is idle
//   tx_data  : payload, [7:0] = byte 0 (sent first), [15:8] = byte 1
//   send16   : 1 = send both bytes, 0 = byte 0 only
//   busy     : transfer in progress
//   tx_done  : one-cycle pulse when the whole transfer completes
interface uart_tx_seq16_if;
    logic        tx_start;
    logic [15:0] tx_data;
    logic        send16;
    logic        busy;
    logic        tx_done;

    modport master (output tx_start, tx_data, send16, input  busy, tx_done);
    modport slave  (input  tx_start, tx_data, send16, output busy, tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises tick_o for one
// cycle on the last count of every bit period; the counter then reloads
// to 0. clr_i holds the counter at 0 so a frame starts on a full period.
//   clock, reset : system clock, async active-high reset
//   clr_i        : hold counter at zero
//   tick_o       : one-cycle bit-boundary strobe
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/uart_tx_seq16.sv
// UART transmitter for the operand/ALU-control transmit sequencer.
// Sends byte 0, or byte 0 then byte 1 back-to-back, as 8N1 frames
// (8E1 data+parity when UART_TX_PARITY_EN is defined).
//   clock, reset : system clock, async active-high reset
//   seq          : sequencer handshake (uart_tx_seq16_if.slave)
//   tx           : serial line, idles high, registered
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data).
// CLKS_PER_BIT (CLK_FREQ/BAUD_RATE) must be at least 2.
module uart_tx_seq16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic               clock,
    input  logic               reset,
    uart_tx_seq16_if.slave     seq,
    output logic               tx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    tx_state_t   state_q;
    logic [15:0] data_q;
    logic        s16_q;
    logic        byte_q;
    logic [2:0]  bit_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        tick;
    logic [7:0]  cur_byte;

    assign cur_byte = byte_q ? data_q[15:8] : data_q[7:0];

    // Timer is held cleared while idle so the start bit gets a full period.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            s16_q   <= 1'b0;
            byte_q  <= 1'b0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (seq.tx_start) begin
                        data_q  <= seq.tx_data;
                        s16_q   <= seq.send16;
                        byte_q  <= 1'b0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= cur_byte[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= ^cur_byte;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_byte[bit_q + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (!byte_q && s16_q) begin
                            // Second byte follows immediately: stop bit
                            // goes straight into the next start bit.
                            byte_q  <= 1'b1;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            byte_q  <= 1'b0;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx          = tx_q;
    assign seq.busy    = busy_q;
    assign seq.tx_done = done_q;

endmodule
